// File: rtl/dma_cfg_pkg.sv
// Register map, bit positions and state/status encodings
// shared by the DMA configuration sequencer and its bus engine.
package dma_cfg_pkg;

  localparam logic [9:0] MM2S_CR  = 10'h000;
  localparam logic [9:0] MM2S_SR  = 10'h004;
  localparam logic [9:0] MM2S_SA  = 10'h018;
  localparam logic [9:0] MM2S_LEN = 10'h028;
  localparam logic [9:0] S2MM_CR  = 10'h030;
  localparam logic [9:0] S2MM_SR  = 10'h034;
  localparam logic [9:0] S2MM_DA  = 10'h048;
  localparam logic [9:0] S2MM_LEN = 10'h058;
  localparam logic [9:0] S2MM_OFS = S2MM_CR - MM2S_CR;

  localparam int CR_RS         = 0;
  localparam int CR_IOC_IRQ_EN = 12;
  localparam int CR_ERR_IRQ_EN = 14;

  localparam int SR_ERR_LO  = 4;
  localparam int SR_ERR_HI  = 6;
  localparam int SR_IOC_IRQ = 12;
  localparam int SR_ERR_IRQ = 14;

  localparam logic [31:0] CR_START =
    (32'd1 << CR_RS) | (32'd1 << CR_IOC_IRQ_EN) |
    (32'd1 << CR_ERR_IRQ_EN);
  localparam logic [31:0] SR_IOC_W1C = 32'd1 << SR_IOC_IRQ;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_DMA_ERR = 3'd1,
    ST_BUS_ERR = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_CFG_ERR = 3'd4
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CR,
    S_WR_ADR,
    S_WR_LEN,
    S_POLL_WAIT,
    S_POLL_RD,
    S_CLR_SR,
    S_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    M_IDLE,
    M_WR,
    M_B,
    M_AR,
    M_R
  } bus_state_e;

  // Channel registers share one layout; S2MM sits at a fixed offset.
  function automatic logic [9:0] reg_off(
    input logic       s2mm,
    input logic [9:0] mm2s_off
  );
    return s2mm ? mm2s_off + S2MM_OFS : mm2s_off;
  endfunction

endpackage

// File: rtl/axil_single_master.sv
// Single-outstanding AXI-Lite master: one write or one read per
// request, ack pulses in the response cycle with data and error.
module axil_single_master #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_wr,
  input  logic                  req_rd,
  input  logic [9:0]            req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] ack_rdata,
  output logic                  ack_err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [9:0]            awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [9:0]            araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp
);
  import dma_cfg_pkg::*;

  bus_state_e            state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [9:0]            awaddr_q, awaddr_d;
  logic [9:0]            araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= M_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    ack       = 1'b0;
    ack_err   = 1'b0;
    ack_rdata = rdata;
    unique case (state_q)
      M_IDLE: begin
        if (req_wr) begin
          state_d   = M_WR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = req_addr;
          wdata_d   = req_wdata;
        end else if (req_rd) begin
          state_d   = M_AR;
          arvalid_d = 1'b1;
          araddr_d  = req_addr;
        end
      end
      M_WR: begin
        // AW and W retire independently, in either order.
        if (awready) awvalid_d = 1'b0;
        if (wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = M_B;
        end
      end
      M_B: begin
        if (bvalid && bready_q) begin
          bready_d = 1'b0;
          state_d  = M_IDLE;
          ack      = 1'b1;
          ack_err  = (bresp != 2'b00);
        end
      end
      M_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = M_R;
        end
      end
      M_R: begin
        if (rvalid && rready_q) begin
          rready_d = 1'b0;
          state_d  = M_IDLE;
          ack      = 1'b1;
          ack_err  = (rresp != 2'b00);
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = awaddr_q;
  assign araddr  = araddr_q;
  assign wdata   = wdata_q;

endmodule

// File: rtl/dma_lite_cfg_sequencer.sv
// Programs one simple-mode AXI DMA transfer per command, polls
// DMASR for completion, clears IOC and reports one status word.
module dma_lite_cfg_sequencer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int LEN_WIDTH    = 26,
  parameter int POLL_GAP     = 16,
  parameter int POLL_TIMEOUT = 4096
) (
  input  logic                  axi_aclk,
  input  logic                  axi_resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  done_valid,
  output logic [2:0]            done_status,
  output logic                  s_axi_lite_awvalid,
  input  logic                  s_axi_lite_awready,
  output logic [9:0]            s_axi_lite_awaddr,
  output logic                  s_axi_lite_wvalid,
  input  logic                  s_axi_lite_wready,
  output logic [DATA_WIDTH-1:0] s_axi_lite_wdata,
  input  logic                  s_axi_lite_bvalid,
  output logic                  s_axi_lite_bready,
  input  logic [1:0]            s_axi_lite_bresp,
  output logic                  s_axi_lite_arvalid,
  input  logic                  s_axi_lite_arready,
  output logic [9:0]            s_axi_lite_araddr,
  input  logic                  s_axi_lite_rvalid,
  output logic                  s_axi_lite_rready,
  input  logic [DATA_WIDTH-1:0] s_axi_lite_rdata,
  input  logic [1:0]            s_axi_lite_rresp
);
  import dma_cfg_pkg::*;

  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 2);
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP);

  seq_state_e            state_q, state_d;
  status_e               status_q, status_d;
  logic                  dir_q, dir_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  issued_q, issued_d;
  logic [PW-1:0]         poll_cnt_q, poll_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;

  logic                  req_wr, req_rd;
  logic [9:0]            m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  ack, ack_err;
  logic [DATA_WIDTH-1:0] ack_rdata;
  logic                  sr_ioc, sr_err;
  logic                  poll_last, poll_sat;
  logic                  unused_sr;

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q    <= S_IDLE;
      status_q   <= ST_OK;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= 1'b0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Each bus step launches exactly one request, then waits for ack.
  assign req_wr = !issued_q &&
    (state_q inside {S_WR_CR, S_WR_ADR, S_WR_LEN, S_CLR_SR});
  assign req_rd = !issued_q && (state_q == S_POLL_RD);

  always_comb begin
    m_addr  = reg_off(dir_q, MM2S_CR);
    m_wdata = DATA_WIDTH'(CR_START);
    unique case (state_q)
      S_WR_ADR: begin
        m_addr  = reg_off(dir_q, MM2S_SA);
        m_wdata = DATA_WIDTH'(addr_q);
      end
      S_WR_LEN: begin
        m_addr  = reg_off(dir_q, MM2S_LEN);
        m_wdata = DATA_WIDTH'(len_q);
      end
      S_POLL_RD: m_addr = reg_off(dir_q, MM2S_SR);
      S_CLR_SR: begin
        m_addr  = reg_off(dir_q, MM2S_SR);
        m_wdata = DATA_WIDTH'(SR_IOC_W1C);
      end
      default: ;
    endcase
  end

  assign sr_ioc = ack_rdata[SR_IOC_IRQ];
  assign sr_err = (|ack_rdata[SR_ERR_HI:SR_ERR_LO]) ||
                  ack_rdata[SR_ERR_IRQ];
  assign poll_last = poll_cnt_q >= PW'(POLL_TIMEOUT - 1);
  assign poll_sat  = poll_cnt_q == PW'(POLL_TIMEOUT);
  assign unused_sr = ^{ack_rdata[DATA_WIDTH-1:15], ack_rdata[13],
                       ack_rdata[11:7], ack_rdata[3:0]};

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    if (req_wr || req_rd) issued_d = 1'b1;
    if (ack) issued_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d      = cmd_dir;
          addr_d     = cmd_addr;
          len_d      = cmd_len;
          poll_cnt_d = '0;
          if (cmd_len == '0) begin
            state_d  = S_DONE;
            status_d = ST_CFG_ERR;
          end else begin
            state_d = S_WR_CR;
          end
        end
      end
      S_WR_CR:  if (ack) state_d = S_WR_ADR;
      S_WR_ADR: if (ack) state_d = S_WR_LEN;
      S_WR_LEN: begin
        if (ack) begin
          state_d   = S_POLL_WAIT;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_POLL_WAIT: begin
        if (gap_cnt_q <= GW'(1)) state_d = S_POLL_RD;
        else gap_cnt_d = gap_cnt_q - GW'(1);
      end
      S_POLL_RD: begin
        if (ack) begin
          if (sr_ioc) begin
            state_d = S_CLR_SR;
          end else if (sr_err) begin
            state_d  = S_DONE;
            status_d = ST_DMA_ERR;
          end else begin
            if (!poll_sat) poll_cnt_d = poll_cnt_q + PW'(1);
            if (poll_last) begin
              state_d  = S_DONE;
              status_d = ST_TIMEOUT;
            end else begin
              state_d   = S_POLL_WAIT;
              gap_cnt_d = GAP_LOAD;
            end
          end
        end
      end
      S_CLR_SR: begin
        if (ack) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A failed response on any step skips everything that remains.
    if (ack && ack_err) begin
      state_d  = S_DONE;
      status_d = ST_BUS_ERR;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign done_valid  = (state_q == S_DONE);
  assign done_status = status_q;

  axil_single_master #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bus (
    .clk      (axi_aclk),
    .rst_n    (axi_resetn),
    .req_wr   (req_wr),
    .req_rd   (req_rd),
    .req_addr (m_addr),
    .req_wdata(m_wdata),
    .ack      (ack),
    .ack_rdata(ack_rdata),
    .ack_err  (ack_err),
    .awvalid  (s_axi_lite_awvalid),
    .awready  (s_axi_lite_awready),
    .awaddr   (s_axi_lite_awaddr),
    .wvalid   (s_axi_lite_wvalid),
    .wready   (s_axi_lite_wready),
    .wdata    (s_axi_lite_wdata),
    .bvalid   (s_axi_lite_bvalid),
    .bready   (s_axi_lite_bready),
    .bresp    (s_axi_lite_bresp),
    .arvalid  (s_axi_lite_arvalid),
    .arready  (s_axi_lite_arready),
    .araddr   (s_axi_lite_araddr),
    .rvalid   (s_axi_lite_rvalid),
    .rready   (s_axi_lite_rready),
    .rdata    (s_axi_lite_rdata),
    .rresp    (s_axi_lite_rresp)
  );

endmodule

// File: tb/tb_dma_lite_cfg_sequencer.sv
// Bench: scripted AXI-Lite DMA register slave plus a
// transaction-level model of the expected register traffic.
module tb_dma_lite_cfg_sequencer;

  localparam int GAP = 16;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [25:0] cmd_len = '0;
  logic        done_valid;
  logic [2:0]  done_status;
  logic        awvalid, awready = 1'b0;
  logic [9:0]  awaddr;
  logic        wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00;
  logic        arvalid, arready = 1'b0;
  logic [9:0]  araddr;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // slave scenario knobs (read index k is 1-based, 0 = never)
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  int err_wr_idx = 99;
  int ioc_at = 0, err_at = 0, rerr_at = 0;

  bit          aw_got, w_got, ar_got;
  int          aw_wait, w_wait, ar_wait;
  logic [9:0]  cur_awaddr;
  logic [31:0] cur_wdata;
  int          n_wr, n_rd, n_aw_hs, n_w_hs, proto_err, n_valid_seen;
  logic [41:0] wr_log[$];
  logic [9:0]  rd_addr_log[$];
  int          rd_time_log[$];

  dma_lite_cfg_sequencer #(
    .POLL_GAP    (GAP),
    .POLL_TIMEOUT(TMO)
  ) dut (
    .axi_aclk          (clk),
    .axi_resetn        (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_dir           (cmd_dir),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .done_valid        (done_valid),
    .done_status       (done_status),
    .s_axi_lite_awvalid(awvalid),
    .s_axi_lite_awready(awready),
    .s_axi_lite_awaddr (awaddr),
    .s_axi_lite_wvalid (wvalid),
    .s_axi_lite_wready (wready),
    .s_axi_lite_wdata  (wdata),
    .s_axi_lite_bvalid (bvalid),
    .s_axi_lite_bready (bready),
    .s_axi_lite_bresp  (bresp),
    .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready),
    .s_axi_lite_araddr (araddr),
    .s_axi_lite_rvalid (rvalid),
    .s_axi_lite_rready (rready),
    .s_axi_lite_rdata  (rdata),
    .s_axi_lite_rresp  (rresp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] sr_word(input int k);
    if (k == ioc_at) return 32'h0000_1000;
    if (k == err_at) return 32'h0000_4020;
    return 32'h0000_0002;
  endfunction

  // handshake monitor
  always @(posedge clk) begin
    if (rst_n) begin
      if (awvalid || wvalid || arvalid) n_valid_seen++;
      if (awvalid && awready) begin
        if (aw_got) proto_err++;
        aw_got = 1'b1;
        cur_awaddr = awaddr;
        n_aw_hs++;
      end
      if (wvalid && wready) begin
        if (w_got) proto_err++;
        w_got = 1'b1;
        cur_wdata = wdata;
        n_w_hs++;
      end
      if (bvalid && bready) begin
        wr_log.push_back({cur_awaddr, cur_wdata});
        aw_got = 1'b0;
        w_got = 1'b0;
        n_wr++;
      end
      if (arvalid && arready) begin
        if (ar_got) proto_err++;
        ar_got = 1'b1;
        rd_addr_log.push_back(araddr);
        rd_time_log.push_back(cyc);
      end
      if (rvalid && rready) begin
        ar_got = 1'b0;
        n_rd++;
      end
    end
  end

  // slave response driver
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
    end else begin
      if (awvalid && !aw_got) begin
        awready = (aw_wait >= aw_dly);
        aw_wait++;
      end else begin
        awready = 1'b0;
        aw_wait = 0;
      end
      if (wvalid && !w_got) begin
        wready = (w_wait >= w_dly);
        w_wait++;
      end else begin
        wready = 1'b0;
        w_wait = 0;
      end
      if (arvalid && !ar_got) begin
        arready = (ar_wait >= ar_dly);
        ar_wait++;
      end else begin
        arready = 1'b0;
        ar_wait = 0;
      end
      bvalid = aw_got && w_got;
      bresp  = (n_wr == err_wr_idx) ? 2'b10 : 2'b00;
      rvalid = ar_got;
      rdata  = sr_word(n_rd + 1);
      rresp  = (n_rd + 1 == rerr_at) ? 2'b10 : 2'b00;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_addr_log.delete();
    rd_time_log.delete();
    n_wr = 0; n_rd = 0; n_aw_hs = 0; n_w_hs = 0;
    proto_err = 0; n_valid_seen = 0;
  endtask

  task automatic run_cmd(input string tag, input bit dir,
                         input logic [31:0] addr,
                         input logic [25:0] len);
    logic [41:0] exp_wr[$];
    logic [9:0]  base;
    logic [2:0]  exp_st;
    int          exp_rd, ev, n;
    base = dir ? 10'h030 : 10'h000;
    exp_rd = 0;
    exp_st = 3'd0;
    if (len == 0) begin
      exp_st = 3'd4;
    end else begin
      exp_wr.push_back({base, 32'h0000_5001});
      exp_wr.push_back({base + 10'h018, addr});
      exp_wr.push_back({base + 10'h028, 32'(len)});
      if (err_wr_idx < 3) begin
        while (exp_wr.size() > err_wr_idx + 1) void'(exp_wr.pop_back());
        exp_st = 3'd2;
      end else begin
        ev = 0;
        for (int k = 1; k <= TMO && ev == 0; k++)
          if (k == rerr_at || k == ioc_at || k == err_at) ev = k;
        if (ev == 0) begin
          exp_rd = TMO;
          exp_st = 3'd3;
        end else begin
          exp_rd = ev;
          if (ev == rerr_at) exp_st = 3'd2;
          else if (ev == ioc_at) begin
            exp_wr.push_back({base + 10'h004, 32'h0000_1000});
            exp_st = (err_wr_idx == 3) ? 3'd2 : 3'd0;
          end else exp_st = 3'd1;
        end
      end
    end

    clear_logs();
    @(negedge clk);
    check({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_dir = ~dir;
    cmd_addr = $urandom; cmd_len = 26'($urandom);
    check({tag, "_busy"}, cmd_ready, 0);
    n = 0;
    while (!done_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done_valid, 1);
    if (len == 0) check({tag, "_lat"}, n, 0);
    check({tag, "_status"}, done_status, exp_st);
    @(negedge clk);
    check({tag, "_pulse"}, done_valid, 0);
    check({tag, "_rdy_back"}, cmd_ready, 1);
    check({tag, "_hold"}, done_status, exp_st);
    check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
    check({tag, "_aw_hs"}, n_aw_hs, exp_wr.size());
    check({tag, "_w_hs"}, n_w_hs, exp_wr.size());
    check({tag, "_nrd"}, rd_addr_log.size(), exp_rd);
    for (int i = 0; i < rd_addr_log.size(); i++)
      check($sformatf("%s_ra%0d", tag, i), rd_addr_log[i], base + 10'h004);
    for (int i = 1; i < rd_time_log.size(); i++)
      check($sformatf("%s_gap%0d", tag, i),
            (rd_time_log[i] - rd_time_log[i-1]) >= GAP, 1);
    check({tag, "_proto"}, proto_err, 0);
    if (len == 0) check({tag, "_quiet"}, n_valid_seen, 0);
  endtask

  task automatic set_scn(input int ioc, input int err, input int rerr,
                         input int wr_err);
    ioc_at = ioc; err_at = err; rerr_at = rerr; err_wr_idx = wr_err;
  endtask

  initial begin
    int n, seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done_valid, 0);
    check("rst_status", done_status, 0);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_addr", {awaddr, araddr, wdata}, 0);
    rst_n = 1'b1;

    set_scn(3, 0, 0, 99);
    run_cmd("t1_mm2s", 1'b0, 32'h1000_0000, 26'd256);

    set_scn(1, 0, 0, 99);
    aw_dly = 0; w_dly = 3;
    run_cmd("t2a_s2mm", 1'b1, 32'h2000_0040, 26'd64);
    aw_dly = 3; w_dly = 0;
    run_cmd("t2b_s2mm", 1'b1, 32'h2000_0040, 26'd64);
    aw_dly = 0; w_dly = 0;

    set_scn(2, 0, 0, 1);
    run_cmd("t3_bresp", 1'b0, 32'h3000_0000, 26'd128);

    set_scn(0, 2, 0, 99);
    run_cmd("t4_dmaerr", 1'b1, 32'h4000_0100, 26'd32);

    set_scn(0, 0, 0, 99);
    run_cmd("t5_tmo", 1'b0, 32'h5000_0000, 26'd16);

    set_scn(1, 0, 0, 99);
    run_cmd("t6_len0", 1'b1, 32'h6000_0000, 26'd0);

    set_scn(0, 0, 2, 99);
    run_cmd("t7_rresp", 1'b0, 32'h7000_0000, 26'd8);

    for (int it = 0; it < 8; it++) begin
      aw_dly = $urandom_range(0, 4);
      w_dly  = $urandom_range(0, 4);
      ar_dly = $urandom_range(0, 4);
      set_scn($urandom_range(0, TMO), $urandom_range(0, TMO),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO) : 0,
              $urandom_range(0, 9));
      run_cmd($sformatf("rnd%0d", it), 1'($urandom),
              $urandom, 26'($urandom_range(1, 26'h3ff_ffff)));
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0;

    // reset while the LENGTH write is stalled on awready
    set_scn(0, 0, 0, 99);
    clear_logs();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b0;
    cmd_addr = 32'h0800_0000; cmd_len = 26'd32;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (n_wr < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    aw_dly = 1000;
    n = 0;
    while (!awvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_aw", awvalid, 1);
    check("rst_mid_addr", awaddr, 10'h028);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valids", {awvalid, wvalid, arvalid}, 0);
    check("rst_mid_readys", {bready, rready}, 0);
    check("rst_mid_cmd", cmd_ready, 1);
    check("rst_mid_done", done_valid, 0);
    rst_n = 1'b1;
    aw_dly = 0;
    seen = n_valid_seen;
    repeat (20) @(negedge clk);
    check("rst_mid_quiet", n_valid_seen, seen);

    set_scn(1, 0, 0, 99);
    run_cmd("post_rst", 1'b1, 32'h0900_0000, 26'd4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
